// File: rtl/axi4_resp_pkg.sv
// Shared AXI4 response/burst types and the burst address-step helper.
package axi4_resp_pkg;

  localparam int unsigned AXI_ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  // Burst control captured from AW/AR at acceptance
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    axi_burst_e burst;
  } axi_ax_ctl_t;

  // Next beat address; WRAP stays inside the aligned (len+1)<<size block, RSVD steps like INCR
  function automatic logic [AXI_ADDR_MAX_W-1:0] axi_next_addr(
    input logic [AXI_ADDR_MAX_W-1:0] addr,
    input logic [2:0]                size,
    input logic [7:0]                len,
    input axi_burst_e                burst
  );
    logic [AXI_ADDR_MAX_W-1:0] step;
    logic [AXI_ADDR_MAX_W-1:0] incr;
    logic [AXI_ADDR_MAX_W-1:0] wmask;
    logic [AXI_ADDR_MAX_W-1:0] nxt;
    step  = AXI_ADDR_MAX_W'(1) << size;
    incr  = addr + step;
    wmask = ((AXI_ADDR_MAX_W'(len) + AXI_ADDR_MAX_W'(1)) << size) - AXI_ADDR_MAX_W'(1);
    case (burst)
      FIXED:   nxt = addr;
      WRAP:    nxt = (addr & ~wmask) | (incr & wmask);
      default: nxt = incr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sram_be_1p.sv
// Single-port block RAM with byte write enables and registered 1-cycle read.
module sram_be_1p #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned DATA_W = 512
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_we,
  input  logic [DATA_W/8-1:0]        i_be,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_re,
  input  logic                       i_zero,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  output logic [DATA_W-1:0]          o_rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-masked write; storage is never reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read register holds its value between reads; i_zero forces a zero word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= i_zero ? '0 : r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_sram_responder.sv
// AXI4 subordinate terminating one port in on-chip RAM; one burst in flight, round-robin AW/AR.
module axi4_sram_responder
  import axi4_resp_pkg::*;
#(
  parameter int unsigned       ID_W   = 6,
  parameter int unsigned       ADDR_W = 64,
  parameter int unsigned       DATA_W = 512,
  parameter int unsigned       DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic                chipset_clk,
  input  logic                chipset_rst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int unsigned       STRB_W  = DATA_W / 8;
  localparam int unsigned       IDX_LSB = $clog2(STRB_W);
  localparam int unsigned       RAM_AW  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN    = ADDR_W'(DEPTH) << IDX_LSB;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_e;

  state_e            r_state, w_state_nxt;
  logic              r_prio_wr;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  axi_ax_ctl_t       r_ctl;
  logic [7:0]        r_beat;
  logic              r_cfg_err, r_werr, r_wdec;
  logic              r_wready, r_bvalid, r_rvalid, r_rlast;
  axi_resp_e         r_bresp, r_rresp;

  logic              w_aw_take, w_ar_take, w_ram_we, w_ram_re;
  logic              w_pick_wr, w_pick_rd, w_whs, w_rhs, w_bhs;
  logic              w_last_beat, w_dec, w_wlast_err, w_sel_cfg_err;
  logic [ADDR_W-1:0] w_off;
  logic [RAM_AW-1:0] w_ram_addr;
  axi_ax_ctl_t       w_sel_ctl;
  axi_resp_e         w_beat_resp, w_final_bresp;

  // Channel arbitration and per-beat address decode
  always_comb begin
    w_pick_wr   = s_axi_awvalid && (r_prio_wr || !s_axi_arvalid);
    w_pick_rd   = s_axi_arvalid && !w_pick_wr;
    w_whs       = r_wready && s_axi_wvalid;
    w_rhs       = r_rvalid && s_axi_rready;
    w_bhs       = r_bvalid && s_axi_bready;
    w_last_beat = (r_beat == r_ctl.len);
    w_off       = r_addr - BASE;
    w_dec       = (w_off >= SPAN);
    w_ram_addr  = w_off[IDX_LSB +: RAM_AW];
    w_wlast_err = (s_axi_wlast != w_last_beat);
    w_beat_resp = w_dec ? DECERR : (r_cfg_err ? SLVERR : OKAY);
    w_final_bresp = (r_wdec || w_dec) ? DECERR :
                    ((r_werr || w_wlast_err || r_cfg_err) ? SLVERR : OKAY);
    w_sel_ctl.len   = w_pick_wr ? s_axi_awlen  : s_axi_arlen;
    w_sel_ctl.size  = w_pick_wr ? s_axi_awsize : s_axi_arsize;
    w_sel_ctl.burst = axi_burst_e'(w_pick_wr ? s_axi_awburst : s_axi_arburst);
    w_sel_cfg_err   = (w_sel_ctl.size > 3'(IDX_LSB)) || (w_sel_ctl.burst == RSVD) ||
                      ((w_sel_ctl.burst == WRAP) &&
                       !(w_sel_ctl.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end

  // State register
  always_ff @(posedge chipset_clk or posedge chipset_rst) begin
    if (chipset_rst) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state and RAM strobes
  always_comb begin
    w_state_nxt = r_state;
    w_aw_take   = 1'b0;
    w_ar_take   = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_wr) begin
          w_aw_take   = 1'b1;
          w_state_nxt = WR_DATA;
        end else if (w_pick_rd) begin
          w_ar_take   = 1'b1;
          w_state_nxt = RD_ADDR;
        end
      end
      WR_DATA: begin
        if (w_whs) begin
          w_ram_we = !w_dec;
          if (w_last_beat) w_state_nxt = WR_RESP;
        end
      end
      WR_RESP: if (w_bhs) w_state_nxt = IDLE;
      RD_ADDR: begin
        w_ram_re    = 1'b1;
        w_state_nxt = RD_DATA;
      end
      RD_DATA: if (w_rhs) w_state_nxt = r_rlast ? IDLE : RD_ADDR;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst context, beat counting, sticky errors and registered handshake outputs
  always_ff @(posedge chipset_clk or posedge chipset_rst) begin
    if (chipset_rst) begin
      r_prio_wr <= 1'b1;
      r_id      <= '0;
      r_addr    <= '0;
      r_ctl     <= '0;
      r_beat    <= '0;
      r_cfg_err <= 1'b0;
      r_werr    <= 1'b0;
      r_wdec    <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_bresp   <= OKAY;
      r_rresp   <= OKAY;
    end else begin
      r_wready <= (w_state_nxt == WR_DATA);
      r_bvalid <= (w_state_nxt == WR_RESP);
      r_rvalid <= (w_state_nxt == RD_DATA);
      if (w_aw_take || w_ar_take) begin
        r_id      <= w_aw_take ? s_axi_awid : s_axi_arid;
        r_addr    <= w_aw_take ? s_axi_awaddr : s_axi_araddr;
        r_ctl     <= w_sel_ctl;
        r_cfg_err <= w_sel_cfg_err;
        r_beat    <= '0;
        r_werr    <= 1'b0;
        r_wdec    <= 1'b0;
        if (s_axi_awvalid && s_axi_arvalid) r_prio_wr <= !r_prio_wr;
      end
      if (w_whs) begin
        r_werr <= r_werr || w_wlast_err;
        r_wdec <= r_wdec || w_dec;
        if (w_last_beat) r_bresp <= w_final_bresp;
      end
      if (w_ram_re) begin
        r_rlast <= w_last_beat;
        r_rresp <= w_beat_resp;
      end
      if ((w_whs && !w_last_beat) || (w_rhs && !r_rlast)) begin
        r_beat <= r_beat + 8'd1;
        r_addr <= ADDR_W'(axi_next_addr(AXI_ADDR_MAX_W'(r_addr), r_ctl.size, r_ctl.len,
                                        r_ctl.burst));
      end
    end
  end

  sram_be_1p #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (chipset_clk),
    .i_rst   (chipset_rst),
    .i_we    (w_ram_we),
    .i_be    (s_axi_wstrb),
    .i_wdata (s_axi_wdata),
    .i_re    (w_ram_re),
    .i_zero  (w_dec),
    .i_addr  (w_ram_addr),
    .o_rdata (s_axi_rdata)
  );

  assign s_axi_awready = w_aw_take;
  assign s_axi_arready = w_ar_take;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bid     = r_id;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rid     = r_id;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;

endmodule
